// File: rtl/crossing_sequencer_if.sv
// crossing_sequencer_if: bundles the timebase, durations, sensors and status
// outputs of the level-crossing sequencer.
//   master : drives tick, t0, t1, sensor_in, sensor_out, fault_clr;
//            observes present_state, count, lights, gate_down, fault.
//   slave  : the sequencer side (mirror of master).
interface crossing_sequencer_if;
  logic        tick;
  logic [18:0] t0;
  logic [18:0] t1;
  logic        sensor_in;
  logic        sensor_out;
  logic        fault_clr;
  logic [3:0]  present_state;
  logic [18:0] count;
  logic        lights;
  logic        gate_down;
  logic        fault;

  modport master (
    output tick, t0, t1, sensor_in, sensor_out, fault_clr,
    input  present_state, count, lights, gate_down, fault
  );

  modport slave (
    input  tick, t0, t1, sensor_in, sensor_out, fault_clr,
    output present_state, count, lights, gate_down, fault
  );
endinterface

// File: rtl/crossing_sequencer.sv
// crossing_sequencer: level-crossing state machine with its 19-bit duration
// timer. Every state entry loads the timer with t0 (IDLE, CLOSED, GATE_UP)
// or t1 (WARN, GATE_DOWN, FAULT); the timer counts down on tick pulses.
// Ports:
//   clk   - system clock, rising edge
//   rst_n - asynchronous active-low reset (deassertion synchronous at system level)
//   bus   - slave side of crossing_sequencer_if:
//           in : tick, t0, t1, sensor_in, sensor_out, fault_clr
//           out: present_state, count, lights, gate_down, fault (all registered)
module crossing_sequencer (
  input logic                 clk,
  input logic                 rst_n,
  crossing_sequencer_if.slave bus
);

  localparam logic [3:0] StIdle     = 4'b0000;
  localparam logic [3:0] StWarn     = 4'b0001;
  localparam logic [3:0] StGateDown = 4'b0010;
  localparam logic [3:0] StClosed   = 4'b0011;
  localparam logic [3:0] StGateUp   = 4'b0100;
  localparam logic [3:0] StFault    = 4'b1000;

  logic [3:0]  state_q, state_d;
  logic [18:0] count_q, count_d;
  logic        lights_q, lights_d;
  logic        gate_down_q, gate_down_d;
  logic        fault_q, fault_d;

  logic expire;
  logic load;
  logic timed;
  logic use_short;

  // Expiry on the tick where the remaining count is 1 (or a zero load), so a
  // loaded value N lasts max(N,1) ticks.
  assign expire = bus.tick & (count_q <= 19'd1);

  // IDLE and FAULT park the timer; only the four sequencing states count.
  assign timed = (state_q == StWarn) || (state_q == StGateDown) ||
                 (state_q == StClosed) || (state_q == StGateUp);

  // Next-state: first matching condition per state wins.
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    case (state_q)
      StIdle: begin
        if (bus.sensor_in) begin
          state_d = StWarn;
          load    = 1'b1;
        end
      end
      StWarn: begin
        if (expire) begin
          state_d = StGateDown;
          load    = 1'b1;
        end
      end
      StGateDown: begin
        if (expire) begin
          state_d = StClosed;
          load    = 1'b1;
        end
      end
      StClosed: begin
        // Exit sensor beats the timeout when both land on the same cycle.
        if (bus.sensor_out) begin
          state_d = StGateUp;
          load    = 1'b1;
        end else if (expire) begin
          state_d = StFault;
          load    = 1'b1;
        end
      end
      StGateUp: begin
        // A new approaching train re-closes the gate before the lift completes.
        if (bus.sensor_in) begin
          state_d = StGateDown;
          load    = 1'b1;
        end else if (expire) begin
          state_d = StIdle;
          load    = 1'b1;
        end
      end
      StFault: begin
        // Only clear once the track reads empty.
        if (bus.fault_clr && !bus.sensor_out) begin
          state_d = StGateUp;
          load    = 1'b1;
        end
      end
      default: begin
        state_d = StFault;
        load    = 1'b1;
      end
    endcase
  end

  // Duration select follows the state being entered.
  assign use_short = (state_d == StIdle) || (state_d == StClosed) || (state_d == StGateUp);

  // Timer: a load masks any coincident tick. Decrement only happens without
  // expiry, so count_q >= 2 here and the timer cannot underflow.
  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = use_short ? bus.t0 : bus.t1;
    end else if (timed && bus.tick && !expire) begin
      count_d = count_q - 19'd1;
    end
  end

  // Moore outputs decoded from the next state so they are registered
  // alongside present_state.
  always_comb begin
    lights_d    = 1'b1;
    gate_down_d = 1'b0;
    fault_d     = 1'b0;
    case (state_d)
      StIdle: begin
        lights_d = 1'b0;
      end
      StGateDown, StClosed: begin
        gate_down_d = 1'b1;
      end
      StFault: begin
        gate_down_d = 1'b1;
        fault_d     = 1'b1;
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      count_q     <= 19'd0;
      lights_q    <= 1'b0;
      gate_down_q <= 1'b0;
      fault_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      lights_q    <= lights_d;
      gate_down_q <= gate_down_d;
      fault_q     <= fault_d;
    end
  end

  assign bus.present_state = state_q;
  assign bus.count         = count_q;
  assign bus.lights        = lights_q;
  assign bus.gate_down     = gate_down_q;
  assign bus.fault         = fault_q;

endmodule

// File: tb/tb_crossing_sequencer.sv
// Bench for crossing_sequencer: vector table, directed multi-cycle sequences,
// then randomized traffic against a dwell-based reference model.
module tb_crossing_sequencer;

  localparam logic [3:0] S_IDLE = 4'b0000;
  localparam logic [3:0] S_WARN = 4'b0001;
  localparam logic [3:0] S_GD   = 4'b0010;
  localparam logic [3:0] S_CL   = 4'b0011;
  localparam logic [3:0] S_UP   = 4'b0100;
  localparam logic [3:0] S_FLT  = 4'b1000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  crossing_sequencer_if bus_if();

  crossing_sequencer dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  int n_cmp = 0;
  int n_fail = 0;

  // Reference model: state plus the duration loaded on entry and ticks consumed.
  logic [3:0] m_state = S_IDLE;
  int         m_len = 0;
  int         m_ticks = 0;

  typedef struct {
    logic        rst_n;
    logic        tick;
    logic        sin;
    logic        sout;
    logic        fclr;
    logic [3:0]  st;
    logic [18:0] cnt;
    logic        l;
    logic        g;
    logic        f;
  } vec_t;

  vec_t vecs[18];

  function automatic vec_t mk(input logic r, input logic tk, input logic si, input logic so,
                              input logic fc, input logic [3:0] st, input int cnt,
                              input logic l, input logic g, input logic f);
    vec_t v;
    v.rst_n = r; v.tick = tk; v.sin = si; v.sout = so; v.fclr = fc;
    v.st = st; v.cnt = 19'(cnt); v.l = l; v.g = g; v.f = f;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic tk, input logic si, input logic so, input logic fc);
    bus_if.tick       = tk;
    bus_if.sensor_in  = si;
    bus_if.sensor_out = so;
    bus_if.fault_clr  = fc;
  endtask

  function automatic bit short_state(input logic [3:0] s);
    return (s == S_IDLE) || (s == S_CL) || (s == S_UP);
  endfunction

  // Advance the model by one clock edge using the inputs currently driven.
  task automatic model_edge();
    logic [3:0] nxt;
    bit         done;
    int         life;
    if (!rst_n) begin
      m_state = S_IDLE; m_len = 0; m_ticks = 0;
      return;
    end
    life = (m_len == 0) ? 1 : m_len;
    done = bus_if.tick && (m_ticks + 1 >= life);
    nxt  = m_state;
    case (m_state)
      S_IDLE: if (bus_if.sensor_in) nxt = S_WARN;
      S_WARN: if (done) nxt = S_GD;
      S_GD:   if (done) nxt = S_CL;
      S_CL:   if (bus_if.sensor_out) nxt = S_UP; else if (done) nxt = S_FLT;
      S_UP:   if (bus_if.sensor_in) nxt = S_GD; else if (done) nxt = S_IDLE;
      S_FLT:  if (bus_if.fault_clr && !bus_if.sensor_out) nxt = S_UP;
      default: nxt = S_FLT;
    endcase
    if (nxt != m_state) begin
      m_len   = short_state(nxt) ? int'(bus_if.t0) : int'(bus_if.t1);
      m_ticks = 0;
    end else if (bus_if.tick && m_state != S_IDLE && m_state != S_FLT) begin
      m_ticks++;
    end
    m_state = nxt;
  endtask

  task automatic cycle();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic check_model(input int idx);
    check($sformatf("rnd%0d state", idx), 32'(bus_if.present_state), 32'(m_state));
    check($sformatf("rnd%0d count", idx), 32'(bus_if.count), m_len - m_ticks);
    check($sformatf("rnd%0d lights", idx), 32'(bus_if.lights), 32'(m_state != S_IDLE));
    check($sformatf("rnd%0d gate_down", idx), 32'(bus_if.gate_down),
          32'(m_state == S_GD || m_state == S_CL || m_state == S_FLT));
    check($sformatf("rnd%0d fault", idx), 32'(bus_if.fault), 32'(m_state == S_FLT));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    cycle();
    cycle();
    rst_n = 1'b1;
  endtask

  // Run edges while in state 'code', ticking once every 'per' cycles; n = edges taken.
  task automatic dwell(input logic [3:0] code, input int per, output int n);
    n = 0;
    while (bus_if.present_state == code && n < 1000) begin
      bus_if.tick = ((n % per) == per - 1);
      cycle();
      n++;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    bus_if.t0 = 19'd1;
    bus_if.t1 = 19'd2;
    drive(1'b0, 1'b0, 1'b0, 1'b0);

    // ---- vector table: t0=1, t1=2 ----
    vecs[0]  = mk(0, 0, 0, 0, 0, S_IDLE, 0, 0, 0, 0);
    vecs[1]  = mk(1, 1, 0, 0, 0, S_IDLE, 0, 0, 0, 0);
    vecs[2]  = mk(1, 0, 1, 0, 0, S_WARN, 2, 1, 0, 0);
    vecs[3]  = mk(1, 1, 1, 0, 0, S_WARN, 1, 1, 0, 0);
    vecs[4]  = mk(1, 0, 0, 0, 0, S_WARN, 1, 1, 0, 0);
    vecs[5]  = mk(1, 1, 0, 0, 0, S_GD,   2, 1, 1, 0);
    vecs[6]  = mk(1, 1, 0, 0, 0, S_GD,   1, 1, 1, 0);
    vecs[7]  = mk(1, 1, 0, 0, 0, S_CL,   1, 1, 1, 0);
    vecs[8]  = mk(1, 0, 0, 0, 0, S_CL,   1, 1, 1, 0);
    vecs[9]  = mk(1, 1, 0, 0, 0, S_FLT,  2, 1, 1, 1);
    vecs[10] = mk(1, 1, 0, 1, 1, S_FLT,  2, 1, 1, 1);
    vecs[11] = mk(1, 0, 0, 0, 1, S_UP,   1, 1, 0, 0);
    vecs[12] = mk(1, 1, 1, 0, 0, S_GD,   2, 1, 1, 0);
    vecs[13] = mk(1, 1, 0, 0, 0, S_GD,   1, 1, 1, 0);
    vecs[14] = mk(1, 1, 0, 0, 0, S_CL,   1, 1, 1, 0);
    vecs[15] = mk(1, 1, 0, 1, 0, S_UP,   1, 1, 0, 0);
    vecs[16] = mk(1, 1, 0, 0, 0, S_IDLE, 1, 0, 0, 0);
    vecs[17] = mk(1, 1, 0, 0, 0, S_IDLE, 1, 0, 0, 0);

    for (int i = 0; i < 18; i++) begin
      rst_n = vecs[i].rst_n;
      drive(vecs[i].tick, vecs[i].sin, vecs[i].sout, vecs[i].fclr);
      cycle();
      check($sformatf("vec%0d state", i), 32'(bus_if.present_state), 32'(vecs[i].st));
      check($sformatf("vec%0d count", i), 32'(bus_if.count), 32'(vecs[i].cnt));
      check($sformatf("vec%0d lights", i), 32'(bus_if.lights), 32'(vecs[i].l));
      check($sformatf("vec%0d gate_down", i), 32'(bus_if.gate_down), 32'(vecs[i].g));
      check($sformatf("vec%0d fault", i), 32'(bus_if.fault), 32'(vecs[i].f));
    end

    // ---- nominal pass: t0=3, t1=5, tick every cycle ----
    do_reset();
    bus_if.t0 = 19'd3;
    bus_if.t1 = 19'd5;
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    cycle();
    check("nom warn state", 32'(bus_if.present_state), 32'(S_WARN));
    check("nom warn count", 32'(bus_if.count), 32'd5);
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    dwell(S_WARN, 1, n);
    check("nom warn ticks", n, 5);
    check("nom gd state", 32'(bus_if.present_state), 32'(S_GD));
    check("nom gd gate", 32'(bus_if.gate_down), 32'd1);
    dwell(S_GD, 1, n);
    check("nom gd ticks", n, 5);
    check("nom closed state", 32'(bus_if.present_state), 32'(S_CL));
    check("nom closed count", 32'(bus_if.count), 32'd3);
    cycle();
    cycle();
    check("nom closed count2", 32'(bus_if.count), 32'd1);
    // sensor_out lands on the expiry tick: exit must win over fault
    bus_if.sensor_out = 1'b1;
    cycle();
    check("nom up state", 32'(bus_if.present_state), 32'(S_UP));
    check("nom up gate", 32'(bus_if.gate_down), 32'd0);
    check("nom up count", 32'(bus_if.count), 32'd3);
    bus_if.sensor_out = 1'b0;
    dwell(S_UP, 1, n);
    check("nom up ticks", n, 3);
    check("nom idle state", 32'(bus_if.present_state), 32'(S_IDLE));
    check("nom idle lights", 32'(bus_if.lights), 32'd0);

    // ---- exit timeout then fault clear ----
    do_reset();
    bus_if.t0 = 19'd4;
    bus_if.t1 = 19'd1;
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    cycle();
    bus_if.sensor_in = 1'b0;
    dwell(S_WARN, 1, n);
    dwell(S_GD, 1, n);
    check("to closed state", 32'(bus_if.present_state), 32'(S_CL));
    dwell(S_CL, 1, n);
    check("to closed ticks", n, 4);
    check("to fault state", 32'(bus_if.present_state), 32'(S_FLT));
    check("to fault flag", 32'(bus_if.fault), 32'd1);
    check("to fault count", 32'(bus_if.count), 32'd1);
    drive(1'b1, 1'b0, 1'b1, 1'b1);
    cycle();
    cycle();
    check("to clr blocked", 32'(bus_if.present_state), 32'(S_FLT));
    check("to fault hold count", 32'(bus_if.count), 32'd1);
    bus_if.sensor_out = 1'b0;
    cycle();
    check("to clr up", 32'(bus_if.present_state), 32'(S_UP));
    check("to clr fault", 32'(bus_if.fault), 32'd0);
    check("to up count", 32'(bus_if.count), 32'd4);
    // re-close on the GATE_UP expiry tick; t1 sampled at this load edge
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    cycle();
    cycle();
    cycle();
    check("sim up count1", 32'(bus_if.count), 32'd1);
    bus_if.t1 = 19'd6;
    bus_if.sensor_in = 1'b1;
    cycle();
    check("sim reclose state", 32'(bus_if.present_state), 32'(S_GD));
    check("sim reclose count", 32'(bus_if.count), 32'd6);

    // ---- zero durations: 1-tick states ----
    do_reset();
    bus_if.t0 = 19'd0;
    bus_if.t1 = 19'd0;
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    cycle();
    bus_if.sensor_in = 1'b0;
    check("zero warn count", 32'(bus_if.count), 32'd0);
    dwell(S_WARN, 1, n);
    check("zero warn ticks", n, 1);
    dwell(S_GD, 1, n);
    check("zero gd ticks", n, 1);
    dwell(S_CL, 1, n);
    check("zero closed ticks", n, 1);
    check("zero fault state", 32'(bus_if.present_state), 32'(S_FLT));

    // ---- max duration counts down without wrap ----
    do_reset();
    bus_if.t1 = 19'h7FFFF;
    drive(1'b0, 1'b1, 1'b0, 1'b0);
    cycle();
    check("max load", 32'(bus_if.count), 32'h7FFFF);
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    cycle();
    cycle();
    cycle();
    check("max dec", 32'(bus_if.count), 32'h7FFFC);
    bus_if.tick = 1'b0;
    cycle();
    check("max hold", 32'(bus_if.count), 32'h7FFFC);

    // ---- sparse tick: 1 in 4 stretches durations x4 ----
    do_reset();
    bus_if.t1 = 19'd2;
    drive(1'b0, 1'b1, 1'b0, 1'b0);
    cycle();
    bus_if.sensor_in = 1'b0;
    dwell(S_WARN, 4, n);
    check("sparse warn cycles", n, 8);
    dwell(S_GD, 4, n);
    check("sparse gd cycles", n, 8);

    // ---- asynchronous reset mid GATE_DOWN ----
    do_reset();
    bus_if.t1 = 19'd5;
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    cycle();
    bus_if.sensor_in = 1'b0;
    dwell(S_WARN, 1, n);
    cycle();
    cycle();
    cycle();
    check("rst pre count", 32'(bus_if.count), 32'd2);
    check("rst pre state", 32'(bus_if.present_state), 32'(S_GD));
    #2;
    rst_n = 1'b0;
    #1;
    check("rst async state", 32'(bus_if.present_state), 32'(S_IDLE));
    check("rst async count", 32'(bus_if.count), 32'd0);
    check("rst async lights", 32'(bus_if.lights), 32'd0);
    check("rst async gate", 32'(bus_if.gate_down), 32'd0);
    check("rst async fault", 32'(bus_if.fault), 32'd0);
    cycle();
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cycle();
      check($sformatf("rst wait%0d", i), 32'(bus_if.present_state), 32'(S_IDLE));
    end
    bus_if.sensor_in = 1'b1;
    cycle();
    check("rst restart", 32'(bus_if.present_state), 32'(S_WARN));
    bus_if.sensor_in = 1'b0;

    // ---- illegal state code ----
    force dut.state_q = 4'b0111;
    #1;
    release dut.state_q;
    cycle();
    check("ill state", 32'(bus_if.present_state), 32'(S_FLT));
    check("ill lights", 32'(bus_if.lights), 32'd1);
    check("ill gate", 32'(bus_if.gate_down), 32'd1);
    check("ill fault", 32'(bus_if.fault), 32'd1);

    // ---- randomized traffic against the model ----
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      bus_if.t0         = 19'($urandom_range(0, 5));
      bus_if.t1         = 19'($urandom_range(0, 5));
      bus_if.tick       = ($urandom % 3) != 0;
      bus_if.sensor_in  = ($urandom % 8) == 0;
      bus_if.sensor_out = ($urandom % 6) == 0;
      bus_if.fault_clr  = ($urandom % 4) == 0;
      rst_n             = ($urandom % 500) != 0;
      cycle();
      check_model(i);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
